// File: rtl/pkt_cell_rr_arb.sv
// Round-robin arbiter that lends a shared packet path and cell path to one requester
// at a time, holding the grant until that owner has sent its EOP beat and CELLSZ cells.
module pkt_cell_rr_arb #(
  parameter int REQ_NUM = 4,
  parameter int PDWID   = 128,
  parameter int PMWID   = 32,
  parameter int EOP_POS = 1,
  parameter int CDWID   = 128,
  parameter int CELLSZ  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQ_NUM-1:0]       in_pkt_vld,
  output logic [REQ_NUM-1:0]       in_pkt_rdy,
  input  logic [REQ_NUM*PDWID-1:0] in_pkt_dat,
  input  logic [REQ_NUM*PMWID-1:0] in_pkt_msg,
  input  logic [REQ_NUM-1:0]       in_cell_vld,
  output logic [REQ_NUM-1:0]       in_cell_rdy,
  input  logic [REQ_NUM*CDWID-1:0] in_cell_dat,
  output logic                     out_pkt_vld,
  output logic [PDWID-1:0]         out_pkt_dat,
  output logic [PMWID-1:0]         out_pkt_msg,
  input  logic                     out_pkt_rdy,
  output logic                     out_cell_vld,
  output logic [CDWID-1:0]         out_cell_dat,
  input  logic                     out_cell_rdy,
  output logic [REQ_NUM-1:0]       out_grant,
  output logic                     out_busy
);

  localparam int IW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam logic [3:0] CELL_LAST = 4'(CELLSZ);
  localparam logic [IW-1:0] PTR_INIT = IW'(REQ_NUM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      ptr, ptr_nxt;
  logic [IW-1:0]      gidx, gidx_nxt;
  logic [IW-1:0]      cand;
  logic [REQ_NUM-1:0] grant, grant_nxt;
  logic [REQ_NUM-1:0] req;
  logic               pkt_done, pkt_done_nxt;
  logic [3:0]         cell_cnt, cell_cnt_nxt;
  logic               cell_open;
  logic               eop;
  logic               pkt_hs;
  logic               cell_hs;
  logic               found;

  // Index k places after base, wrapping at REQ_NUM (k is at most REQ_NUM).
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= REQ_NUM) begin
      s = s - REQ_NUM;
    end else begin
      s = s;
    end
    return IW'(s);
  endfunction

  assign req       = in_pkt_vld & in_cell_vld;
  assign out_grant = grant;
  assign out_busy  = (state == BUSY);
  assign pkt_hs    = out_pkt_vld & out_pkt_rdy;
  assign cell_hs   = out_cell_vld & out_cell_rdy;

  // Datapath mux and per-path handshake gating for the current owner.
  always_comb begin
    in_pkt_rdy   = '0;
    in_cell_rdy  = '0;
    out_pkt_vld  = 1'b0;
    out_cell_vld = 1'b0;
    out_pkt_dat  = in_pkt_dat[int'(gidx)*PDWID +: PDWID];
    out_pkt_msg  = in_pkt_msg[int'(gidx)*PMWID +: PMWID];
    out_cell_dat = in_cell_dat[int'(gidx)*CDWID +: CDWID];
    eop          = in_pkt_msg[int'(gidx)*PMWID + EOP_POS];
    cell_open    = (cell_cnt < CELL_LAST);
    if (state == BUSY) begin
      out_pkt_vld       = in_pkt_vld[gidx] & ~pkt_done;
      in_pkt_rdy[gidx]  = out_pkt_rdy & ~pkt_done;
      out_cell_vld      = in_cell_vld[gidx] & cell_open;
      in_cell_rdy[gidx] = out_cell_rdy & cell_open;
    end else begin
      out_pkt_vld  = 1'b0;
      out_cell_vld = 1'b0;
    end
  end

  // Arbitration in IDLE, completion tracking in BUSY.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    gidx_nxt     = gidx;
    grant_nxt    = grant;
    pkt_done_nxt = pkt_done;
    cell_cnt_nxt = cell_cnt;
    cand         = '0;
    found        = 1'b0;
    case (state)
      IDLE: begin
        for (int k = 1; k <= REQ_NUM; k++) begin
          cand = wrap_add(ptr, k);
          if (!found && req[cand]) begin
            found           = 1'b1;
            gidx_nxt        = cand;
            ptr_nxt         = cand;
            grant_nxt       = '0;
            grant_nxt[cand] = 1'b1;
            state_nxt       = BUSY;
          end else begin
            found = found;
          end
        end
      end
      BUSY: begin
        if (pkt_hs && eop) begin
          pkt_done_nxt = 1'b1;
        end else begin
          pkt_done_nxt = pkt_done;
        end
        if (cell_hs) begin
          cell_cnt_nxt = cell_cnt + 4'd1;
        end else begin
          cell_cnt_nxt = cell_cnt;
        end
        // Same-cycle last beats count, so completion looks at the next values.
        if (pkt_done_nxt && (cell_cnt_nxt == CELL_LAST)) begin
          state_nxt    = IDLE;
          pkt_done_nxt = 1'b0;
          cell_cnt_nxt = 4'd0;
          grant_nxt    = '0;
        end else begin
          state_nxt = BUSY;
        end
      end
      default: begin
        state_nxt    = IDLE;
        pkt_done_nxt = 1'b0;
        cell_cnt_nxt = 4'd0;
        grant_nxt    = '0;
      end
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PTR_INIT;
      gidx     <= '0;
      grant    <= '0;
      pkt_done <= 1'b0;
      cell_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gidx     <= gidx_nxt;
      grant    <= grant_nxt;
      pkt_done <= pkt_done_nxt;
      cell_cnt <= cell_cnt_nxt;
    end
  end

endmodule
